// File: rtl/mem_pkg.sv
// Shared load/store encodings for the memory decode and load-return stages.
// Holds memOp/memSize codes, source and fault-cause codes, per-load metadata.
package mem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam logic [1:0] BYTE     = 2'b00;
    localparam logic [1:0] HALFWORD = 2'b01;
    localparam logic [1:0] WORD     = 2'b10;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_UNMAPPED = 2'b10;

    typedef enum logic [1:0] {
        SRC_RAM  = 2'b00,
        SRC_BUF  = 2'b01,
        SRC_DIN  = 2'b10,
        SRC_NONE = 2'b11
    } loadSrc_t;

    // Metadata carried alongside a load while its BRAM read is in flight.
    typedef struct packed {
        logic              valid;
        logic [1:0]        offset;
        logic [1:0]        size;
        logic              sext;
        logic [RD_W-1:0]   rd;
        loadSrc_t          src;
        logic [1:0]        cause;
        logic [XLEN-1:0]   din;
    } loadMeta_t;

    // Misalignment outranks unmapped; size 2'b11 is never a legal access.
    function automatic logic [1:0] classifyFault(input logic [1:0] size,
                                                 input logic [1:0] offset,
                                                 input logic       anyEn);
        logic misaligned;
        misaligned = (size == 2'b11)
                   || ((size == HALFWORD) && offset[0])
                   || ((size == WORD) && (offset != 2'b00));
        if (misaligned)  return FAULT_MISALIGN;
        else if (!anyEn) return FAULT_UNMAPPED;
        else             return FAULT_NONE;
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Picks the addressed byte/halfword/word out of a 32-bit read word and extends it.
// Ports: d (read word), swapped (d is in store-swapped lane order), offset
// (addr[1:0]), memSize, sext (sign- vs zero-extend), result (extended value).
module load_lane_extract
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] d,
    input  logic            swapped,
    input  logic [1:0]      offset,
    input  logic [1:0]      memSize,
    input  logic            sext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] natWord;
    logic [7:0]      byteVal;
    logic [15:0]     halfVal;

    // Undoing the store-path swap first lets both sources share one selector.
    always_comb begin
        natWord = swapped ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d;
        byteVal = natWord[{offset, 3'b000} +: 8];
        halfVal = natWord[{offset[1], 4'b0000} +: 16];
        result  = '0;
        case (memSize)
            BYTE:     result = {{24{sext & byteVal[7]}}, byteVal};
            HALFWORD: result = {{16{sext & halfVal[15]}}, halfVal};
            WORD:     result = natWord;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mem_output_align.sv
// Load-return stage: tracks loads through the BRAM read latency, selects the
// answering source, un-swaps lanes, aligns/extends and registers the result.
// Ports: clk, reset (sync, active-high); issue side addr/memOp/memSize/rd,
// enRam/enBuf/enDin, flush; data ramDout/bufDout (swapped), dinReg (natural);
// result loadValid/loadData/loadRd/loadFault/faultCause (all registered).
module mem_output_align
    import mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1   // legal range 1..3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  addr,
    input  logic [1:0]       memOp,
    input  logic [1:0]       memSize,
    input  logic [RD_W-1:0]  rd,
    input  logic             enRam,
    input  logic             enBuf,
    input  logic             enDin,
    input  logic             flush,
    input  logic [XLEN-1:0]  ramDout,
    input  logic [XLEN-1:0]  bufDout,
    input  logic [XLEN-1:0]  dinReg,
    output logic             loadValid,
    output logic [XLEN-1:0]  loadData,
    output logic [RD_W-1:0]  loadRd,
    output logic             loadFault,
    output logic [1:0]       faultCause
);

    loadMeta_t       issueMeta;
    loadMeta_t       stage [READ_LATENCY];
    loadMeta_t       finalMeta;
    logic [XLEN-1:0] finalWord;
    logic [XLEN-1:0] extracted;
    logic            unusedAddrHi;

    assign unusedAddrHi = ^addr[XLEN-1:2];

    // Metadata captured at issue; DIN is a live register so its value is frozen here.
    always_comb begin
        issueMeta        = '0;
        issueMeta.valid  = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
        issueMeta.offset = addr[1:0];
        issueMeta.size   = memSize;
        issueMeta.sext   = (memOp == MEM_READ_SEXT);
        issueMeta.rd     = rd;
        issueMeta.src    = enRam ? SRC_RAM : enBuf ? SRC_BUF : enDin ? SRC_DIN : SRC_NONE;
        issueMeta.cause  = classifyFault(memSize, addr[1:0], enRam | enBuf | enDin);
        issueMeta.din    = dinReg;
    end

    // Metadata shift register; last stage lines up with BRAM dout.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= issueMeta;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign finalMeta = stage[READ_LATENCY-1];

    // Source mux for the word that answers the load at the final stage.
    always_comb begin
        finalWord = ramDout;
        case (finalMeta.src)
            SRC_BUF: finalWord = bufDout;
            SRC_DIN: finalWord = finalMeta.din;
            default: finalWord = ramDout;
        endcase
    end

    load_lane_extract uExtract (
        .d       (finalWord),
        .swapped (finalMeta.src != SRC_DIN),
        .offset  (finalMeta.offset),
        .memSize (finalMeta.size),
        .sext    (finalMeta.sext),
        .result  (extracted)
    );

    // Result register; payload fields hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadValid  <= 1'b0;
            loadData   <= '0;
            loadRd     <= '0;
            loadFault  <= 1'b0;
            faultCause <= FAULT_NONE;
        end else if (flush) begin
            loadValid  <= 1'b0;
        end else begin
            loadValid <= finalMeta.valid;
            if (finalMeta.valid) begin
                loadRd     <= finalMeta.rd;
                faultCause <= finalMeta.cause;
                loadFault  <= (finalMeta.cause != FAULT_NONE);
                loadData   <= (finalMeta.cause != FAULT_NONE) ? '0 : extracted;
            end
        end
    end

endmodule

// File: doc/mem_output_align.md
Name: mem_output_align

Overview:
- Load-return stage, directly downstream of the memory input/decode stage.
- Tracks every issued load through the BRAM read latency, selects the source that answers it (CPU BRAM, buffer BRAM or DIN register), and undoes the byte-lane swap applied on the store path.
- Aligns the addressed byte/halfword/word, sign- or zero-extends it, and presents a registered result with rd tag to writeback.
- Flags misaligned and unmapped loads as faults instead of returning data.

Parameters:
- READ_LATENCY, 1, BRAM dout cycles after enable (legal values 1..3).
- MEM_DISABLE, 2'b00, memOp encoding: no access.
- MEM_READ_SEXT, 2'b01, memOp encoding: sign-extending load.
- MEM_READ_ZEXT, 2'b10, memOp encoding: zero-extending load.
- MEM_WRITE, 2'b11, memOp encoding: store.
- BYTE, 2'b00, memSize encoding.
- HALFWORD, 2'b01, memSize encoding.
- WORD, 2'b10, memSize encoding.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- addr  in  32  byte address of the access, same cycle as issue
- memOp  in  2  memory operation
- memSize  in  2  access size
- rd  in  5  destination register tag
- enRam  in  1  CPU BRAM selected (from decode stage)
- enBuf  in  1  buffer BRAM selected
- enDin  in  1  DIN register selected
- flush  in  1  kill all in-flight loads
- ramDout  in  32  CPU BRAM read data, swapped lane order
- bufDout  in  32  buffer BRAM read data, swapped lane order
- dinReg  in  32  DIN register value, natural order, not swapped
- loadValid  out  1  result valid, one-cycle pulse per load
- loadData  out  32  extended load result
- loadRd  out  5  tag of the returned load
- loadFault  out  1  qualifies loadValid: fault, no data returned
- faultCause  out  2  01 = misaligned, 10 = unmapped, 00 = no fault

Behaviour:
- Issue: a load issues in any cycle where memOp is MEM_READ_SEXT or MEM_READ_ZEXT.
  - MEM_WRITE and MEM_DISABLE cycles are ignored entirely.
  - One load may issue per cycle. There is no backpressure; writeback always accepts.
- Metadata pipeline: READ_LATENCY stages. Each stage holds valid, addr[1:0], memSize, sext, rd, src (RAM/BUF/DIN/NONE) and fault cause.
  - Stage 0 captures metadata at issue.
  - DIN data is sampled into stage 0 at issue, because it is a live register, not BRAM.
- Fault classification at issue, evaluated in priority order:
  - Misaligned: HALFWORD with addr[0]=1, or WORD with addr[1:0]!=0.
  - Unmapped: none of enRam/enBuf/enDin asserted.
  - memSize=2'b11 is treated as misaligned.
  - A faulted load travels the pipeline like any other load, so order is kept.
- Lane decode at the final stage, using dout d from the selected BRAM:
  - Byte at offset k = d[31-8k -: 8].
  - Halfword, addr[1]=0: {d[23:16], d[31:24]}.
  - Halfword, addr[1]=1: {d[7:0], d[15:8]}.
  - Word: {d[7:0], d[15:8], d[23:16], d[31:24]}.
- DIN source: uses dinReg directly with no swap.
  - Byte k = dinReg[8k+7:8k].
  - Halfword = dinReg[16*addr[1] +: 16].
- Extension: sext replicates the MSB of the extracted field; zext fills with 0.
- Output register: loadValid/loadData/loadRd/loadFault/faultCause are registered at the final stage.
  - Latency is issue cycle + READ_LATENCY + 1; with the default, loadValid rises 2 cycles after issue.
  - Back-to-back loads produce back-to-back loadValid pulses.
- Faulted result: loadData=0, loadFault=1, faultCause set, loadRd = the faulting load's tag.
- Flush:
  - Clears every stage valid and the output valid at the next edge.
  - A load issued in the flush cycle is dropped.
  - A load issued the cycle after flush is tracked normally.
- Reset:
  - All stage valids clear.
  - Outputs reset to loadValid=0, loadData=0, loadRd=0, loadFault=0, faultCause=0.
  - Reset mid-flight drops every pending load and no pulse appears afterwards.
  - Reset has priority over flush.
- Non-valid stages never produce loadValid, regardless of dout contents.

Decomposition:
- Shared package (mem_pkg): memOp/memSize encodings, source encoding (SRC_RAM, SRC_BUF, SRC_DIN, SRC_NONE), fault cause codes. The memory input/decode stage uses the same package.
- Sub-module: load_lane_extract, purely combinational. Inputs: d, swapped flag, addr[1:0], memSize, sext. Output: 32-bit result. The pipeline and control stay in the top module.

Test Plan:
- LB sext, addr=...0001, ramDout=32'h11_F2_33_44 -> after 2 cycles: loadValid=1, loadData=32'hFFFF_FFF2, loadFault=0.
- LHU, addr=...0010, bufDout=32'hAAAA_3412 -> loadData=32'h0000_1234.
- LW, addr=...0000, ramDout=32'h78563412 -> loadData=32'h1234_5678.
- LH, addr=...0001 -> loadFault=1, faultCause=01, loadData=0.
- LW with no enable asserted -> faultCause=10.
- Three back-to-back LW with rd=5,6,7 -> three consecutive loadValid pulses carrying rd 5,6,7 in order.
- LW issued at cycle 0, flush at cycle 1 -> no loadValid.
- LW issued at cycle 2 -> valid at cycle 4.
- LBU from DIN, addr=...0011, dinReg=32'h9A00_0000 -> loadData=32'h0000_009A.
- Reset asserted during an in-flight load -> that load's loadValid never appears and all outputs read 0.
